// File: rtl/gate_selftest.sv
// gate_selftest: sweeps every operand pair through NAND-only logic gates and native
// operators, compares the two results and counts passes/fails, latching the first mismatch.
`default_nettype none

module gate_selftest #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       op_mask,
  input  logic             inject_fault,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             fail_valid,
  output logic [2:0]       fail_op,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  localparam int VW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t           state, state_nx;
  logic [5:0]       mask_q;
  logic             fault_q;
  logic [2:0]       op_q;
  logic [VW-1:0]    vec_q;
  logic             accept, last_vec, has_next;
  logic [2:0]       first_op, next_op;
  logic [WIDTH-1:0] a, b, n_ab, n_aa, n_bb, or_n, dut_res, ref_res;

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a, s1_b, s1_dut, s1_ref;

  function automatic logic [WIDTH-1:0] nand2(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return ~(x & y);
  endfunction

  assign accept   = ((state == IDLE) || (state == DONE)) && start;
  assign last_vec = &vec_q;
  assign a        = vec_q[VW-1:WIDTH];
  assign b        = vec_q[WIDTH-1:0];
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  // Descending scans leave the lowest qualifying bit as the final assignment.
  always_comb begin
    first_op = '0;
    has_next = 1'b0;
    next_op  = op_q;
    for (int i = 5; i >= 0; i--) begin
      if (op_mask[i]) first_op = 3'(i);
      if (mask_q[i] && (3'(i) > op_q)) begin
        has_next = 1'b1;
        next_op  = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = (op_mask != 6'd0) ? RUN : DONE;
      RUN:        if (last_vec && !has_next) state_nx = DRAIN;
      DRAIN:      state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q  <= '0;
      fault_q <= 1'b0;
      op_q    <= '0;
      vec_q   <= '0;
    end else if (accept) begin
      mask_q  <= op_mask;
      fault_q <= inject_fault;
      op_q    <= first_op;
      vec_q   <= '0;
    end else if (state == RUN) begin
      vec_q <= vec_q + VW'(1);
      if (last_vec && has_next) op_q <= next_op;
    end
  end

  // Gate-level path built purely from 2-input NANDs.
  assign n_ab = nand2(a, b);
  assign n_aa = nand2(a, a);
  assign n_bb = nand2(b, b);
  assign or_n = nand2(n_aa, n_bb);

  always_comb begin
    dut_res = '0;
    ref_res = '0;
    case (op_q)
      3'd0: begin dut_res = or_n;                                   ref_res = a | b;    end
      3'd1: begin dut_res = nand2(n_ab, n_ab);                      ref_res = a & b;    end
      3'd2: begin dut_res = n_aa;                                   ref_res = ~a;       end
      3'd3: begin dut_res = n_ab;                                   ref_res = ~(a & b); end
      3'd4: begin dut_res = nand2(or_n, or_n);                      ref_res = ~(a | b); end
      3'd5: begin dut_res = nand2(nand2(a, n_ab), nand2(b, n_ab));  ref_res = a ^ b;    end
      default: ;
    endcase
    dut_res[0] = dut_res[0] ^ fault_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_dut   <= '0;
      s1_ref   <= '0;
    end else begin
      s1_valid <= (state == RUN);
      s1_op    <= op_q;
      s1_a     <= a;
      s1_b     <= b;
      s1_dut   <= dut_res;
      s1_ref   <= ref_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      fail_valid <= 1'b0;
      fail_op    <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
    end else if (accept) begin
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      fail_valid <= 1'b0;
    end else if (s1_valid) begin
      if (s1_dut == s1_ref) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
      end else begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
        if (!fail_valid) begin
          fail_valid <= 1'b1;
          fail_op    <= s1_op;
          fail_a     <= s1_a;
          fail_b     <= s1_b;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gate_selftest.sv
// Bench for gate_selftest: cycle-level behavioural model plus directed literal runs and random runs.
`default_nettype none

module tb_gate_selftest;
  localparam int W = 2;
  localparam int VECS = 1 << (2 * W);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [5:0] op_mask = '0;
  logic inject_fault = 1'b0;

  logic busy, done, fail_valid, busy_s, done_s, fail_valid_s;
  logic [15:0] pass_cnt, fail_cnt;
  logic [3:0] pass_s, fail_s;
  logic [2:0] fail_op, fail_op_s;
  logic [W-1:0] fail_a, fail_b, fail_a_s, fail_b_s;

  int tests = 0;
  int fails = 0;

  gate_selftest #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_mask(op_mask), .inject_fault(inject_fault),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail_valid(fail_valid),
    .fail_op(fail_op), .fail_a(fail_a), .fail_b(fail_b));

  gate_selftest #(.WIDTH(W), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .op_mask(op_mask), .inject_fault(inject_fault),
    .busy(busy_s), .done(done_s), .pass_cnt(pass_s), .fail_cnt(fail_s), .fail_valid(fail_valid_s),
    .fail_op(fail_op_s), .fail_a(fail_a_s), .fail_b(fail_b_s));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k counts edges since the accept edge; run has N vectors, compare lags issue by one edge,
  // so after edge k exactly min(N, k-1) vectors have been scored. An ideal NAND path always matches
  // the native result, so every vector fails iff the fault is injected.
  bit m_run = 0;
  int m_k = 0, m_n = 0, m_first = 0;
  bit m_fault = 0;

  function automatic int lowest(input logic [5:0] m);
    for (int i = 0; i < 6; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic bit m_done();
    return m_run && (m_n == 0 || m_k >= m_n + 1);
  endfunction

  function automatic int imin(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_k = 0; m_n = 0; m_fault = 0; m_first = 0;
    end else if ((!m_run || m_done()) && start) begin
      m_run = 1; m_k = 0;
      m_n = $countones(op_mask) * VECS;
      m_fault = inject_fault;
      m_first = lowest(op_mask);
    end else if (m_run && m_k < 100000) begin
      m_k++;
    end
  end

  always @(negedge clk) begin
    int cnt;
    bit fv;
    cnt = m_run ? imin(m_n, (m_k > 0) ? m_k - 1 : 0) : 0;
    fv  = m_fault && cnt > 0;
    chk("busy", int'(busy), int'(m_run && m_n > 0 && m_k <= m_n));
    chk("done", int'(done), int'(m_done()));
    chk("busy_s", int'(busy_s), int'(m_run && m_n > 0 && m_k <= m_n));
    chk("done_s", int'(done_s), int'(m_done()));
    chk("pass_cnt", int'(pass_cnt), m_fault ? 0 : imin(cnt, 65535));
    chk("fail_cnt", int'(fail_cnt), m_fault ? imin(cnt, 65535) : 0);
    chk("pass_sat", int'(pass_s), m_fault ? 0 : imin(cnt, 15));
    chk("fail_sat", int'(fail_s), m_fault ? imin(cnt, 15) : 0);
    chk("fail_valid", int'(fail_valid), int'(fv));
    chk("fail_valid_s", int'(fail_valid_s), int'(fv));
    if (fv || !m_run) begin
      chk("fail_op", int'(fail_op), fv ? m_first : 0);
      chk("fail_a", int'(fail_a), 0);
      chk("fail_b", int'(fail_b), 0);
    end
  end

  // Returns edges counted with the accept edge as the first, and cycles busy was seen high.
  task automatic do_run(input logic [5:0] mask, input bit fault, input int poke,
                        output int edges, output int busyc);
    @(posedge clk); #2;
    op_mask = mask; inject_fault = fault; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    edges = 1; busyc = 0;
    while (!done && edges < 5000) begin
      if (busy) busyc++;
      if (edges == poke) begin start = 1'b1; op_mask = ~mask; inject_fault = ~fault; end
      else start = 1'b0;
      @(posedge clk); #2;
      edges++;
    end
    start = 1'b0;
  endtask

  initial begin
    int e, bc;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    do_run(6'b000001, 1'b0, 0, e, bc);
    chk("r029_edges", e, 18);
    chk("r029_busy", bc, 17);
    chk("r029_pass", int'(pass_cnt), 16);
    chk("r029_fail", int'(fail_cnt), 0);
    chk("r029_fv", int'(fail_valid), 0);

    do_run(6'b111111, 1'b0, 0, e, bc);
    chk("r030_edges", e, 98);
    chk("r030_pass", int'(pass_cnt), 96);
    chk("r030_fail", int'(fail_cnt), 0);

    do_run(6'b000001, 1'b1, 0, e, bc);
    chk("r031_fail", int'(fail_cnt), 16);
    chk("r031_pass", int'(pass_cnt), 0);
    chk("r031_fv", int'(fail_valid), 1);
    chk("r031_op", int'(fail_op), 0);
    chk("r031_ab", int'({fail_a, fail_b}), 0);

    do_run(6'b000011, 1'b0, 0, e, bc);
    chk("r032_pass_sat", int'(pass_s), 15);
    chk("r032_fail_sat", int'(fail_s), 0);
    chk("r032_pass", int'(pass_cnt), 32);

    do_run(6'b000000, 1'b0, 0, e, bc);
    chk("r033_edges", e, 1);
    chk("r033_busy", bc, 0);
    chk("r033_pass", int'(pass_cnt), 0);

    // Mid-run reset then a start poked during RUN with altered mask/fault.
    @(posedge clk); #2; op_mask = 6'b111111; inject_fault = 1'b1; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("r034_rst_busy", int'(busy), 0);
    chk("r034_rst_cnt", int'(pass_cnt) + int'(fail_cnt), 0);
    chk("r034_rst_fv", int'({fail_valid, fail_op, fail_a, fail_b}), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2 chk("r034_idle", int'({busy, done}), 0);
    do_run(6'b000001, 1'b0, 5, e, bc);
    chk("r034_edges", e, 18);
    chk("r034_pass", int'(pass_cnt), 16);
    chk("r034_fail", int'(fail_cnt), 0);

    // Random runs: model compares every cycle; starts, mask and fault toggle arbitrarily.
    for (int i = 0; i < 16; i++) begin
      int len;
      @(posedge clk); #2;
      op_mask = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom);
      inject_fault = 1'($urandom);
      start = 1'b1;
      len = $urandom_range(1, 110);
      for (int c = 0; c < len; c++) begin
        @(posedge clk); #2;
        start = ($urandom_range(0, 7) == 0);
        op_mask = 6'($urandom);
        inject_fault = 1'($urandom);
        if (c == len / 2 && $urandom_range(0, 4) == 0) rst_n = 1'b0;
        else rst_n = 1'b1;
      end
      start = 1'b0; rst_n = 1'b1;
      repeat (3) @(posedge clk);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/gate_selftest.md
GATE_SELFTEST -- requirements
Module: gate_selftest

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits; legal range 1..8.
REQ-002 Parameter CNT_W, default 16: width of the pass and fail counters; legal range 4..32.
REQ-003 clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous assert, active-low, synchronous deassert at the block boundary.
REQ-005 start  input  1: run request; sampled only in IDLE or DONE.
REQ-006 op_mask  input  6: enables ops 0 OR, 1 AND, 2 NOT (a only), 3 NAND, 4 NOR, 5 XOR; sampled on start acceptance.
REQ-007 inject_fault  input  1: when set, inverts bit 0 of the NAND-path result for the whole run; sampled on start acceptance.
REQ-008 busy  output  1: high in RUN and DRAIN.
REQ-009 done  output  1: high in DONE; held until the next start is accepted or reset.
REQ-010 pass_cnt  output  CNT_W: number of matching vectors.
REQ-011 fail_cnt  output  CNT_W: number of mismatching vectors.
REQ-012 fail_valid  output  1: set when the first mismatch has been captured.
REQ-013 fail_op  output  3: op index of the first mismatch.
REQ-014 fail_a, fail_b  output  WIDTH each: operands of the first mismatch.

Function
REQ-015 Datapath: every op is computed twice, bitwise. The DUT path uses only 2-input NAND primitives (NOT = NAND(x,x); AND = NOT(NAND); OR = NAND(NOT a, NOT b); NOR = NOT(OR); XOR = 4-NAND form). The reference path uses native operators.
REQ-016 FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE -> RUN on start when op_mask != 0.
- IDLE/DONE -> DONE on start when op_mask == 0; this is one cycle later, with counters cleared and no vectors run.
REQ-017 On start acceptance, clear pass_cnt, fail_cnt and fail_valid, latch op_mask and inject_fault, and set the op index to the lowest set mask bit.
REQ-018 In RUN, issue one vector per cycle: {a,b} counts 0 .. 2^(2*WIDTH)-1, with b as the low half.
- After the last vector, advance to the next higher set mask bit and restart {a,b} at 0.
- After the last vector of the highest set op, go to DRAIN.
REQ-019 Ops whose mask bit is clear consume zero cycles; NOT sweeps the full {a,b} space with b ignored.
REQ-020 Pipeline: the issued vector is registered (stage 1, both results computed), then compared and counted one cycle later (stage 2). Compare latency is 1 cycle after issue.
REQ-021 DRAIN lasts exactly 1 cycle, for the last compare, then goes to DONE. With N total vectors, done rises on the (N+2)th rising edge after the start-accept edge.
REQ-022 Compare: the full WIDTH-bit results must be equal for a pass. A match increments pass_cnt; otherwise fail_cnt increments.
REQ-023 Both counters saturate at 2^CNT_W-1 and never wrap.
REQ-024 The first mismatch of a run loads fail_op/fail_a/fail_b and sets fail_valid. Later mismatches do not change these outputs.
REQ-025 start in RUN or DRAIN is ignored. op_mask and inject_fault changes mid-run have no effect.
REQ-026 Outputs hold their final values in DONE until the next accepted start.

Reset
REQ-027 On rst_n low, take state IDLE and force busy=0, done=0, pass_cnt=0, fail_cnt=0, fail_valid=0, fail_op=0, fail_a=0, fail_b=0; the pipeline valid flag is cleared.
REQ-028 Reset mid-run aborts without a partial count. After release, the block waits in IDLE for start.

Verification
REQ-029 WIDTH=2, op_mask=6'b000001, fault=0, start pulse -> busy for 17 cycles, done on the 18th edge, pass_cnt=16, fail_cnt=0, fail_valid=0.
REQ-030 WIDTH=2, op_mask=6'b111111, fault=0 -> pass_cnt=96, fail_cnt=0, done on the 98th edge.
REQ-031 WIDTH=2, op_mask=6'b000001, fault=1 -> fail_cnt=16, pass_cnt=0, fail_valid=1, fail_op=0, fail_a=0, fail_b=0.
REQ-032 WIDTH=2, CNT_W=4, op_mask=6'b000011 -> pass_cnt saturates at 15, fail_cnt=0.
REQ-033 op_mask=0 start -> done one cycle later, busy never asserted, counters 0.
REQ-034 Stimulus with rst_n pulsed low mid-RUN and a start asserted during RUN -> immediate IDLE with all outputs 0 on reset; the start in RUN is ignored and the count is unchanged.
